// File: rtl/com_stream_ctrl.sv
// Host stream controller: loads host words into shared memory, starts the cores, unloads results.
// Optional build macro COM_CHECKSUM_EN appends an XOR checksum word after the result words.
module com_stream_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int OUT_BASE = 0,
  parameter int OUT_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_start,
  input  logic              core_done,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done,
  output logic              load_overflow
);

  // state  | meaning
  // IDLE   | waiting for first host word (written to address 0 on arrival)
  // LOAD   | writing host words at the load pointer until data_write_done
  // RUN    | core_start pulsed on entry, waiting for core_done
  // UNLOAD | reading result words and streaming them to the host
  // DONE   | finished, waiting for data_write_start to drop
  typedef enum logic [2:0] {IDLE, LOAD, RUN, UNLOAD, DONE} state_t;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(OUT_BASE);
  localparam logic [CNT_W-1:0]  LEN     = CNT_W'(OUT_LEN);
  localparam logic [CNT_W-1:0]  LAST_RD = CNT_W'(OUT_LEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   load_ptr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [CNT_W-1:0]   rd_cnt;
  logic [DATA_W-1:0]  hold_q;
  logic               load_active;
`ifdef COM_CHECKSUM_EN
  logic [DATA_W-1:0]  chk_q;
  logic               chk_phase_q;
`endif

  // Writes happen in the cycle the word is presented; MSB of load_ptr marks a full memory.
  assign load_active = rst_n && (state == IDLE || state == LOAD) &&
                       data_write_start && !load_ptr[ADDR_W];
  assign mem_we      = load_active;
  assign mem_wdata   = load_active ? com_data_in : '0;
  assign mem_addr    = (state == UNLOAD) ? rd_addr : load_ptr[ADDR_W-1:0];

  // Read data arrives one cycle after the address, so the valid word passes straight through.
`ifdef COM_CHECKSUM_EN
  assign com_data_out = chk_phase_q ? chk_q : (output_write_start ? mem_rdata : hold_q);
`else
  assign com_data_out = output_write_start ? mem_rdata : hold_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      load_ptr           <= '0;
      rd_addr            <= '0;
      rd_cnt             <= '0;
      hold_q             <= '0;
      core_start         <= 1'b0;
      output_write_start <= 1'b0;
      output_write_done  <= 1'b0;
      load_overflow      <= 1'b0;
`ifdef COM_CHECKSUM_EN
      chk_q              <= '0;
      chk_phase_q        <= 1'b0;
`endif
    end else begin
      core_start         <= 1'b0;
      output_write_start <= 1'b0;
      output_write_done  <= 1'b0;
      if (output_write_start) hold_q <= com_data_out;
`ifdef COM_CHECKSUM_EN
      chk_phase_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (data_write_start) begin
            load_ptr <= CNT_W'(1);
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (data_write_start) begin
            if (load_ptr[ADDR_W]) load_overflow <= 1'b1;
            else                  load_ptr      <= load_ptr + 1'b1;
          end
          if (data_write_done) begin
            core_start <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            rd_addr <= BASE;
            rd_cnt  <= '0;
`ifdef COM_CHECKSUM_EN
            chk_q   <= '0;
`endif
            state   <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (rd_cnt < LEN) begin
            output_write_start <= 1'b1;
            rd_addr            <= rd_addr + 1'b1;
            rd_cnt             <= rd_cnt + 1'b1;
`ifndef COM_CHECKSUM_EN
            output_write_done  <= (rd_cnt == LAST_RD);
`endif
          end
`ifdef COM_CHECKSUM_EN
          else if (rd_cnt == LEN) begin
            output_write_start <= 1'b1;
            output_write_done  <= 1'b1;
            chk_phase_q        <= 1'b1;
            rd_cnt             <= rd_cnt + 1'b1;
          end
          if (output_write_start && !chk_phase_q) chk_q <= chk_q ^ mem_rdata;
`endif
          if (output_write_done) state <= DONE;
        end
        DONE: begin
          if (!data_write_start) begin
            load_ptr <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_com_stream_ctrl.sv
// Randomized bench for com_stream_ctrl against a word-level model of memory contents and unload order.
module tb_com_stream_ctrl;
  localparam int DW = 16, AW = 3, BASE = 6, LEN = 4, DEPTH = 8;
`ifdef COM_CHECKSUM_EN
  localparam int NV = LEN + 1;
`else
  localparam int NV = LEN;
`endif

  logic          clk, rst_n;
  logic [DW-1:0] com_data_in;
  logic          data_write_start, data_write_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          core_start, core_done;
  logic [DW-1:0] com_data_out;
  logic          output_write_start, output_write_done, load_overflow;

  com_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .OUT_BASE(BASE), .OUT_LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .com_data_in(com_data_in),
    .data_write_start(data_write_start), .data_write_done(data_write_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_start(core_start), .core_done(core_done), .com_data_out(com_data_out),
    .output_write_start(output_write_start), .output_write_done(output_write_done),
    .load_overflow(load_overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory with registered read port
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int            n_pass = 0, n_total = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ovf_exp = 1'b0;
  logic [DW-1:0] words [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_words();
    for (int i = 0; i < words.size(); i++) begin
      data_write_start = 1'b1;
      com_data_in      = words[i];
      data_write_done  = (i == words.size() - 1);
      @(negedge clk);
      check("load_we", mem_we, i < DEPTH);
      if (i < DEPTH) begin
        check("load_addr", mem_addr, i);
        check("load_wdata", mem_wdata, words[i]);
        ref_mem[i] = words[i];
      end
      tick();
    end
    if (words.size() > DEPTH) ovf_exp = 1'b1;
    data_write_start = 1'b0;
    data_write_done  = 1'b0;
    @(negedge clk);
    check("core_start_pulse", core_start, 1);
    check("load_overflow", load_overflow, ovf_exp);
    tick();
  endtask

  task automatic run_to_unload();
    int waits;
    waits = $urandom_range(0, 2);
    for (int k = 0; k < waits; k++) begin
      @(negedge clk);
      check("run_core_start_low", core_start, 0);
      check("run_ows_low", output_write_start, 0);
      tick();
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic txn(input bit idle_poke);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] x;
    if (idle_poke) begin
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      @(negedge clk);
      check("idle_core_done_ignored", output_write_start | core_start, 0);
      tick();
    end
    load_words();
    run_to_unload();
    x = '0;
    for (int k = 0; k < LEN; k++) begin
      exp_q.push_back(ref_mem[(BASE + k) % DEPTH]);
      x ^= ref_mem[(BASE + k) % DEPTH];
    end
`ifdef COM_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    for (int c = 0; c <= NV + 1; c++) begin
      if (c == 1) begin
        data_write_start = 1'b1;
        com_data_in      = DW'($urandom);
      end
      @(negedge clk);
      if (c < LEN) check("unload_addr", mem_addr, (BASE + c) % DEPTH);
      check("unload_we", mem_we, 0);
      if (c >= 1 && c <= NV) begin
        check("out_valid", output_write_start, 1);
        check("out_data", com_data_out, exp_q[c-1]);
        check("out_done", output_write_done, c == NV);
      end else begin
        check("out_idle_valid", output_write_start, 0);
        check("out_idle_done", output_write_done, 0);
      end
      if (c == NV + 1) check("out_hold", com_data_out, exp_q[NV-1]);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("done_no_restart", mem_we | output_write_start | core_start, 0);
      tick();
    end
    data_write_start = 1'b0;
    tick();
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst_n = 1'b0; com_data_in = '0; data_write_start = 1'b0;
    data_write_done = 1'b0; core_done = 1'b0;
    #12;
    check("rst_outputs", {mem_we, mem_addr, mem_wdata, core_start, com_data_out,
                          output_write_start, output_write_done, load_overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    words.delete();
    words.push_back(16'd3); words.push_back(16'd5); words.push_back(16'd7);
    txn(1'b1);
    fill_random(DEPTH);
    txn(1'b0);
    for (int t = 0; t < 5; t++) begin
      fill_random($urandom_range(2, 11));
      txn(1'b0);
    end
    fill_random(11);
    txn(1'b0);

    // Reset during the second unload cycle
    fill_random(3);
    load_words();
    run_to_unload();
    @(negedge clk);
    check("rst_entry_ows", output_write_start, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {mem_we, mem_addr, mem_wdata, core_start, com_data_out,
                              output_write_start, output_write_done, load_overflow}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    ovf_exp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_idle", {mem_we, core_start, output_write_start, output_write_done}, 0);
      check("post_rst_addr", mem_addr, 0);
      tick();
    end
    fill_random($urandom_range(2, 8));
    txn(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
